// File: rtl/devport_ctl.sv
// ---------------------------------------------------------------------------
// devport_ctl : 68030 device-bus I/O cycle timer (setup/strobe/recovery, DSACK, BERR)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module devport_ctl #(
   parameter int                 NCHAN        = 4,
   parameter logic [4*NCHAN-1:0] SETUP_W      = {NCHAN{4'd1}},
   parameter logic [4*NCHAN-1:0] STROBE_W     = {NCHAN{4'd2}},
   parameter logic [4*NCHAN-1:0] RECOV_W      = {NCHAN{4'd0}},
   parameter logic [NCHAN-1:0]   PORT16       = {NCHAN{1'b1}},
   parameter int                 BERR_TIMEOUT = 63
) (
   input  logic             CPU_CLK,
   input  logic             nRST,
   input  logic             nAS,
   input  logic             nDS,
   input  logic             RnW,
   input  logic [NCHAN-1:0] nCHSEL,
   output logic [1:0]       DSACK,
   output logic             BERR,
   output logic             nIORD,
   output logic             nIOWR,
   output logic [NCHAN-1:0] ACTIVE
);

   localparam int         CH_W    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam logic [7:0] BERR_TC = 8'(BERR_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_ACK    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic            strobe_en_q, strobe_en_d;
   logic [1:0]      dsack_q, dsack_d;
   logic [3:0]      recov_q [NCHAN];
   logic [3:0]      recov_d [NCHAN];
   logic [7:0]      wdog_q, wdog_d;

   logic [CH_W-1:0] win_ch;
   logic            win_any;
   logic            end_cycle;

   function automatic logic [3:0] field4(input logic [4*NCHAN-1:0] vec,
                                         input logic [CH_W-1:0]    idx);
      return vec[4*idx +: 4];
   endfunction

   // Lowest-index active select wins; scan downward so the last hit is the lowest.
   always_comb begin
      win_ch  = '0;
      win_any = 1'b0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (!nCHSEL[i]) begin
            win_ch  = CH_W'(i);
            win_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ch_d        = ch_q;
      strobe_en_d = strobe_en_q;
      dsack_d     = dsack_q;
      end_cycle   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!nAS && win_any && (recov_q[win_ch] == 4'd0)) begin
               state_d = S_SETUP;
               ch_d    = win_ch;
               cnt_d   = field4(SETUP_W, win_ch);
            end
         end
         S_SETUP: begin
            if (nAS) begin
               end_cycle = 1'b1;
            end else if (cnt_q == 4'd0) begin
               state_d     = S_STROBE;
               cnt_d       = field4(STROBE_W, ch_q);
               strobe_en_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_STROBE: begin
            if (nAS) begin
               end_cycle = 1'b1;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
               dsack_d = PORT16[ch_q] ? 2'b10 : 2'b01;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            if (nAS || nDS) begin
               end_cycle = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (end_cycle) begin
         state_d     = S_IDLE;
         strobe_en_d = 1'b0;
         dsack_d     = 2'b00;
      end
   end

   // A normal end or abort reloads the finishing channel; all others just drain.
   always_comb begin
      for (int i = 0; i < NCHAN; i++) begin
         if (end_cycle && (ch_q == CH_W'(i))) begin
            recov_d[i] = RECOV_W[4*i +: 4];
         end else if (recov_q[i] != 4'd0) begin
            recov_d[i] = recov_q[i] - 4'd1;
         end else begin
            recov_d[i] = 4'd0;
         end
      end
   end

   always_comb begin
      wdog_d = wdog_q;
      if (nAS) begin
         wdog_d = 8'd0;
      end else if (wdog_q != BERR_TC) begin
         wdog_d = wdog_q + 8'd1;
      end
   end

   always_ff @(posedge CPU_CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         ch_q        <= '0;
         strobe_en_q <= 1'b0;
         dsack_q     <= 2'b00;
         wdog_q      <= 8'd0;
         for (int i = 0; i < NCHAN; i++) begin
            recov_q[i] <= 4'd0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ch_q        <= ch_d;
         strobe_en_q <= strobe_en_d;
         dsack_q     <= dsack_d;
         wdog_q      <= wdog_d;
         for (int i = 0; i < NCHAN; i++) begin
            recov_q[i] <= recov_d[i];
         end
      end
   end

   // Strobes and DSACK gate on nDS so they release without waiting for an edge.
   always_comb begin
      nIORD  = ~(strobe_en_q & ~nDS & RnW);
      nIOWR  = ~(strobe_en_q & ~nDS & ~RnW);
      DSACK  = dsack_q & {2{~nDS}};
      BERR   = (wdog_q == BERR_TC);
      ACTIVE = '0;
      if (state_q != S_IDLE) begin
         ACTIVE[ch_q] = 1'b1;
      end
   end

endmodule

`default_nettype wire
